// File: rtl/contract_retire_tracker.sv
// contract_retire_tracker: shadows an N-stage pipeline and emits contract observables at retirement,
// buffering retired records in a ready/valid trace FIFO with sticky overflow and a retirement counter.
module contract_retire_tracker #(
   parameter int STAGES      = 2,
   parameter int XLEN        = 32,
   parameter int MEM_STAGE   = 1,
   parameter int TRACE_DEPTH = 4,
   parameter int CNT_W       = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [XLEN-1:0]   if_pc,
   input  logic [31:0]       if_instr,
   input  logic              stall,
   input  logic [STAGES-1:0] kill,
   input  logic              mem_val,
   input  logic [XLEN-1:0]   mem_addr,
   output logic              retire_valid,
   output logic [XLEN-1:0]   pc_retire,
   output logic [31:0]       instr_ctr,
   output logic [XLEN-1:0]   dmem_addr_ctr,
   output logic [XLEN-1:0]   exe_reg_pc,
   output logic              trc_valid,
   input  logic              trc_ready,
   output logic [XLEN-1:0]   trc_pc,
   output logic [31:0]       trc_instr,
   output logic [XLEN-1:0]   trc_addr,
   output logic              trc_overflow,
   output logic [CNT_W-1:0]  retire_count
);
   localparam int AW = $clog2(TRACE_DEPTH);
   logic [STAGES-1:0] v_q, v_d;
   logic [XLEN-1:0]   pc_q [STAGES];
   logic [XLEN-1:0]   pc_d [STAGES];
   logic [31:0]       ins_q [STAGES];
   logic [31:0]       ins_d [STAGES];
   logic [XLEN-1:0]   adr_q [STAGES];
   logic [XLEN-1:0]   adr_d [STAGES];
   logic              rv_q, rv_d, ovf_q, ovf_d;
   logic [XLEN-1:0]   prt_q, prt_d, dctr_q, dctr_d;
   logic [31:0]       ictr_q, ictr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [AW:0]       wp_q, wp_d, rp_q, rp_d;
   logic [XLEN-1:0]   fpc_q [TRACE_DEPTH];
   logic [31:0]       fins_q [TRACE_DEPTH];
   logic [XLEN-1:0]   fadr_q [TRACE_DEPTH];
   logic              ret, full, empty, pop, push;
   logic [XLEN-1:0]   mem_sel, ret_addr;

   assign mem_sel  = mem_val ? mem_addr : '0;
   // when the memory stage is the last one, the address is still being computed as it retires
   assign ret_addr = (MEM_STAGE == STAGES - 1) ? mem_sel : adr_q[STAGES-1];
   assign ret      = ~stall & v_q[STAGES-1] & ~kill[STAGES-1];
   assign full     = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
   assign empty    = wp_q == rp_q;
   assign pop      = ~empty & trc_ready;
   assign push     = ret & (~full | pop);

   always_comb begin
      v_d[0]   = stall ? v_q[0] & ~kill[0] : if_valid & ~kill[0];
      pc_d[0]  = stall ? pc_q[0] : if_pc;
      ins_d[0] = stall ? ins_q[0] : if_instr;
      adr_d[0] = stall ? adr_q[0] : '0;
      for (int i = 1; i < STAGES; i++) begin
         v_d[i]   = stall ? v_q[i] & ~kill[i] : v_q[i-1] & ~kill[i-1];
         pc_d[i]  = stall ? pc_q[i] : pc_q[i-1];
         ins_d[i] = stall ? ins_q[i] : ins_q[i-1];
         adr_d[i] = stall ? adr_q[i] : (i - 1 == MEM_STAGE) ? mem_sel : adr_q[i-1];
      end
      rv_d   = ret;
      prt_d  = ret ? pc_q[STAGES-1] : prt_q;
      ictr_d = ret ? ins_q[STAGES-1] : ictr_q;
      dctr_d = ret ? ret_addr : dctr_q;
      cnt_d  = cnt_q + CNT_W'(ret);
      ovf_d  = ovf_q | (ret & full & ~pop);
      wp_d   = wp_q + (AW+1)'(push);
      rp_d   = rp_q + (AW+1)'(pop);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         v_q    <= '0;
         rv_q   <= 1'b0;
         prt_q  <= '0;
         ictr_q <= '0;
         dctr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         wp_q   <= '0;
         rp_q   <= '0;
         for (int i = 0; i < STAGES; i++) begin
            pc_q[i]  <= '0;
            ins_q[i] <= '0;
            adr_q[i] <= '0;
         end
         for (int i = 0; i < TRACE_DEPTH; i++) begin
            fpc_q[i]  <= '0;
            fins_q[i] <= '0;
            fadr_q[i] <= '0;
         end
      end else begin
         v_q    <= v_d;
         rv_q   <= rv_d;
         prt_q  <= prt_d;
         ictr_q <= ictr_d;
         dctr_q <= dctr_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         for (int i = 0; i < STAGES; i++) begin
            pc_q[i]  <= pc_d[i];
            ins_q[i] <= ins_d[i];
            adr_q[i] <= adr_d[i];
         end
         if (push) begin
            fpc_q[wp_q[AW-1:0]]  <= pc_q[STAGES-1];
            fins_q[wp_q[AW-1:0]] <= ins_q[STAGES-1];
            fadr_q[wp_q[AW-1:0]] <= ret_addr;
         end
      end
   end

   assign retire_valid  = rv_q;
   assign pc_retire     = prt_q;
   assign instr_ctr     = ictr_q;
   assign dmem_addr_ctr = dctr_q;
   assign exe_reg_pc    = pc_q[1];
   assign trc_valid     = ~empty;
   assign trc_pc        = fpc_q[rp_q[AW-1:0]];
   assign trc_instr     = fins_q[rp_q[AW-1:0]];
   assign trc_addr      = fadr_q[rp_q[AW-1:0]];
   assign trc_overflow  = ovf_q;
   assign retire_count  = cnt_q;
endmodule

// File: tb/tb_contract_retire_tracker.sv
// tb_contract_retire_tracker: directed table of single-cycle vectors plus hand sequences for
// stall/kill, FIFO overflow and drain, full push+pop, and asynchronous reset mid-flight.
module tb_contract_retire_tracker;
   logic        clock, reset, if_valid, stall, mem_val, trc_ready;
   logic [31:0] if_pc, if_instr, mem_addr;
   logic [1:0]  kill;
   logic        retire_valid, trc_valid, trc_overflow;
   logic [31:0] pc_retire, instr_ctr, dmem_addr_ctr, exe_reg_pc, trc_pc, trc_instr, trc_addr, retire_count;
   int checks = 0;
   int failures = 0;

   contract_retire_tracker dut (
      .clock(clock), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
      .stall(stall), .kill(kill), .mem_val(mem_val), .mem_addr(mem_addr),
      .retire_valid(retire_valid), .pc_retire(pc_retire), .instr_ctr(instr_ctr),
      .dmem_addr_ctr(dmem_addr_ctr), .exe_reg_pc(exe_reg_pc), .trc_valid(trc_valid),
      .trc_ready(trc_ready), .trc_pc(trc_pc), .trc_instr(trc_instr), .trc_addr(trc_addr),
      .trc_overflow(trc_overflow), .retire_count(retire_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic iv; logic [31:0] ipc, iins; logic st; logic [1:0] kl; logic mv; logic [31:0] ma; logic rdy;
      logic rv; logic [31:0] prt, ic, dc, exe; logic tv; logic [31:0] tpc, ta, cnt; logic ovf;
   } vec_t;

   function automatic vec_t mk(logic iv, logic [31:0] ipc, logic [31:0] iins, logic st, logic [1:0] kl,
                               logic mv, logic [31:0] ma, logic rdy, logic rv, logic [31:0] prt,
                               logic [31:0] ic, logic [31:0] dc, logic [31:0] exe, logic tv,
                               logic [31:0] tpc, logic [31:0] ta, logic [31:0] cnt, logic ovf);
      vec_t v;
      v.iv = iv; v.ipc = ipc; v.iins = iins; v.st = st; v.kl = kl; v.mv = mv; v.ma = ma; v.rdy = rdy;
      v.rv = rv; v.prt = prt; v.ic = ic; v.dc = dc; v.exe = exe; v.tv = tv; v.tpc = tpc; v.ta = ta;
      v.cnt = cnt; v.ovf = ovf;
      return v;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
      if_valid = iv; if_pc = pc; if_instr = ins; stall = 1'b0; kill = 2'b00;
      mem_val = 1'b0; mem_addr = '0; trc_ready = rdy;
   endtask

   localparam logic [31:0] P4 = 32'h80000004, I4 = 32'h2003, A4 = 32'h1000;
   vec_t t [16];

   initial begin
      t[0]  = mk(1, 32'h80000000, 32'h13, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      t[1]  = mk(1, P4, I4, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 32'h80000000,  0, 0, 0, 0, 0);
      t[2]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0,  1, 32'h80000000, 32'h13, 0, P4,  1, 32'h80000000, 0, 1, 0);
      t[3]  = mk(0, 0, 0, 0, 2'b00, 1, A4, 0,  1, P4, I4, A4, 0,  1, 32'h80000000, 0, 2, 0);
      t[4]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 1,  0, P4, I4, A4, 0,  1, P4, A4, 2, 0);
      t[5]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 1,  0, P4, I4, A4, 0,  0, 0, 0, 2, 0);
      t[6]  = mk(1, 32'h80000100, 32'h11, 0, 2'b00, 0, 0, 0,  0, P4, I4, A4, 0,  0, 0, 0, 2, 0);
      t[7]  = mk(1, 32'h80000104, 32'h22, 0, 2'b00, 0, 0, 0,  0, P4, I4, A4, 32'h80000100,  0, 0, 0, 2, 0);
      t[8]  = mk(1, 32'h80000108, 32'h44, 1, 2'b00, 0, 0, 0,  0, P4, I4, A4, 32'h80000100,  0, 0, 0, 2, 0);
      t[9]  = mk(0, 0, 0, 1, 2'b10, 0, 0, 0,  0, P4, I4, A4, 32'h80000100,  0, 0, 0, 2, 0);
      t[10] = mk(0, 0, 0, 1, 2'b00, 0, 0, 0,  0, P4, I4, A4, 32'h80000100,  0, 0, 0, 2, 0);
      t[11] = mk(0, 0, 0, 0, 2'b00, 0, 0, 0,  0, P4, I4, A4, 32'h80000104,  0, 0, 0, 2, 0);
      t[12] = mk(0, 0, 0, 0, 2'b00, 0, 0, 0,  1, 32'h80000104, 32'h22, 0, 0,  1, 32'h80000104, 0, 3, 0);
      t[13] = mk(1, 32'h80000200, 32'h33, 0, 2'b01, 0, 0, 0,  0, 32'h80000104, 32'h22, 0, 0,  1, 32'h80000104, 0, 3, 0);
      t[14] = mk(0, 0, 0, 0, 2'b00, 0, 0, 0,  0, 32'h80000104, 32'h22, 0, 32'h80000200,  1, 32'h80000104, 0, 3, 0);
      t[15] = mk(0, 0, 0, 0, 2'b00, 0, 0, 1,  0, 32'h80000104, 32'h22, 0, 0,  0, 0, 0, 3, 0);

      reset = 1'b0;
      drive(0, 0, 0, 0);
      #12;
      chk("rst_retire_valid", 32'(retire_valid), 0);
      chk("rst_trc_valid", 32'(trc_valid), 0);
      chk("rst_count", retire_count, 0);
      chk("rst_pc_retire", pc_retire, 0);
      reset = 1'b1;

      for (int i = 0; i < 16; i++) begin
         if_valid = t[i].iv; if_pc = t[i].ipc; if_instr = t[i].iins; stall = t[i].st; kill = t[i].kl;
         mem_val = t[i].mv; mem_addr = t[i].ma; trc_ready = t[i].rdy;
         step();
         chk($sformatf("v%0d_retire_valid", i), 32'(retire_valid), 32'(t[i].rv));
         chk($sformatf("v%0d_pc_retire", i), pc_retire, t[i].prt);
         chk($sformatf("v%0d_instr_ctr", i), instr_ctr, t[i].ic);
         chk($sformatf("v%0d_dmem_addr_ctr", i), dmem_addr_ctr, t[i].dc);
         chk($sformatf("v%0d_exe_reg_pc", i), exe_reg_pc, t[i].exe);
         chk($sformatf("v%0d_trc_valid", i), 32'(trc_valid), 32'(t[i].tv));
         chk($sformatf("v%0d_retire_count", i), retire_count, t[i].cnt);
         chk($sformatf("v%0d_trc_overflow", i), 32'(trc_overflow), 32'(t[i].ovf));
         if (t[i].tv) begin
            chk($sformatf("v%0d_trc_pc", i), trc_pc, t[i].tpc);
            chk($sformatf("v%0d_trc_addr", i), trc_addr, t[i].ta);
         end
      end

      // five back-to-back retirements into a 4-deep FIFO with no consumer
      for (int j = 0; j < 7; j++) begin
         drive(j < 5, 32'h80000300 + 32'(4 * j), 32'h100 + 32'(j), 0);
         step();
         chk($sformatf("ovf%0d_retire_valid", j), 32'(retire_valid), 32'(j >= 2));
         chk($sformatf("ovf%0d_count", j), retire_count, 32'd3 + 32'(j >= 2 ? j - 1 : 0));
         chk($sformatf("ovf%0d_overflow", j), 32'(trc_overflow), 32'(j == 6));
         if (j >= 2) chk($sformatf("ovf%0d_pc_retire", j), pc_retire, 32'h80000300 + 32'(4 * (j - 2)));
      end
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain%0d_valid", k), 32'(trc_valid), 1);
         chk($sformatf("drain%0d_pc", k), trc_pc, 32'h80000300 + 32'(4 * k));
         chk($sformatf("drain%0d_instr", k), trc_instr, 32'h100 + 32'(k));
         drive(0, 0, 0, 1);
         step();
      end
      chk("drain_empty", 32'(trc_valid), 0);
      chk("drain_overflow_sticky", 32'(trc_overflow), 1);

      // asynchronous reset with two stages valid and three records queued
      for (int j = 0; j < 5; j++) begin
         drive(1, 32'h80000500 + 32'(4 * j), 32'h200 + 32'(j), 0);
         step();
      end
      chk("pre_rst_count", retire_count, 11);
      chk("pre_rst_trc_valid", 32'(trc_valid), 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_retire_valid", 32'(retire_valid), 0);
      chk("arst_pc_retire", pc_retire, 0);
      chk("arst_instr_ctr", instr_ctr, 0);
      chk("arst_dmem_addr", dmem_addr_ctr, 0);
      chk("arst_exe_reg_pc", exe_reg_pc, 0);
      chk("arst_trc_valid", 32'(trc_valid), 0);
      chk("arst_trc_pc", trc_pc, 0);
      chk("arst_overflow", 32'(trc_overflow), 0);
      chk("arst_count", retire_count, 0);
      drive(0, 0, 0, 0);
      #3 reset = 1'b1;
      for (int j = 0; j < 4; j++) begin
         step();
         chk($sformatf("post_rst%0d_retire_valid", j), 32'(retire_valid), 0);
         chk($sformatf("post_rst%0d_count", j), retire_count, 0);
         chk($sformatf("post_rst%0d_trc_valid", j), 32'(trc_valid), 0);
      end

      // fill to full, then retire and pop on the same edge
      for (int j = 0; j < 7; j++) begin
         drive(j < 5, 32'h80000600 + 32'(4 * j), 32'h300 + 32'(j), j == 6);
         step();
         if (j == 5) chk("full_count", retire_count, 4);
      end
      chk("pp_retire_valid", 32'(retire_valid), 1);
      chk("pp_pc_retire", pc_retire, 32'h80000610);
      chk("pp_count", retire_count, 5);
      chk("pp_overflow", 32'(trc_overflow), 0);
      for (int k = 1; k < 5; k++) begin
         chk($sformatf("pp_drain%0d_valid", k), 32'(trc_valid), 1);
         chk($sformatf("pp_drain%0d_pc", k), trc_pc, 32'h80000600 + 32'(4 * k));
         drive(0, 0, 0, 1);
         step();
      end
      chk("pp_empty", 32'(trc_valid), 0);
      chk("pp_overflow_end", 32'(trc_overflow), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/contract_retire_tracker.md
Name: contract_retire_tracker

Overview:
- Parametrised successor to the fixed 2-stage contract taps on the Sodor cores.
- Tracks every fetched instruction through an N-stage pipeline shadow, honouring the global stall and per-stage kill.
- At retirement it emits the contract observables: pc_retire, instr_ctr and dmem_addr_ctr.
- Retired records are also buffered in a ready/valid trace FIFO, with an overflow flag and a retirement counter for the contract checker.

Parameters:
STAGES, 2, number of pipeline stages shadowed; legal range 2..8.
XLEN, 32, PC and address width.
MEM_STAGE, 1, stage index in which the dmem address is computed; must be less than STAGES.
TRACE_DEPTH, 4, trace FIFO entries; power of 2, at least 2.
CNT_W, 32, retire_count width.

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
if_valid  in  1  fetch delivers an instruction this cycle
if_pc  in  XLEN  PC of the fetched instruction
if_instr  in  32  fetched instruction word
stall  in  1  global pipeline stall
kill  in  STAGES  kill[i] discards the entry in stage i this cycle
mem_val  in  1  the MEM_STAGE instruction accesses dmem
mem_addr  in  XLEN  dmem address computed in MEM_STAGE
retire_valid  out  1  one-cycle pulse: a retirement is presented
pc_retire  out  XLEN  PC of the retired instruction
instr_ctr  out  32  instruction word of the retired instruction
dmem_addr_ctr  out  XLEN  dmem address of the retired instruction; 0 if it made no access
exe_reg_pc  out  XLEN  PC held in stage 1 (state invariant tap)
trc_valid  out  1  trace FIFO is non-empty
trc_ready  in  1  consumer accepts the head record
trc_pc  out  XLEN  head record PC
trc_instr  out  32  head record instruction word
trc_addr  out  XLEN  head record dmem address
trc_overflow  out  1  sticky: a record was dropped
retire_count  out  CNT_W  total retirements; wraps at 2^CNT_W

Behaviour:
- Reset:
  - All stage valid bits, registered outputs, FIFO pointers, trc_overflow and retire_count clear to 0 asynchronously while reset is 0.
  - Registers run normally from the first rising clock edge after reset returns to 1.
- Stage state: s[i] = {valid, pc, instr, addr}. exe_reg_pc = s[1].pc.
- Advance (stall=0), on each edge:
  - s[0] loads {if_valid & ~kill[0], if_pc, if_instr, 0}.
  - For i>=1, s[i] loads s[i-1] with valid = s[i-1].valid & ~kill[i-1].
- Kill precedence: kill takes priority over stall. Under stall=1, every s[i] holds, except that kill[i] clears s[i].valid.
- Address capture:
  - When the entry in MEM_STAGE advances, its addr field becomes (mem_val ? mem_addr : 0).
  - If MEM_STAGE = STAGES-1, the retiring record carries that value directly.
- Retirement condition: stall=0, s[STAGES-1].valid=1 and kill[STAGES-1]=0. On that edge:
  - retire_valid is set to 1.
  - pc_retire, instr_ctr and dmem_addr_ctr load from the record.
  - retire_count increments.
  - The record is pushed into the trace FIFO.
- No retirement: retire_valid goes to 0 and pc_retire, instr_ctr, dmem_addr_ctr hold their last values.
- Latency: a fetch sampled at edge e with no stall and no kill gives retire_valid=1 after edge e+STAGES. For STAGES=2 this is 2 cycles.
- Trace FIFO:
  - Circular buffer, registered outputs, no push-to-output bypass; a push into an empty FIFO raises trc_valid after that edge.
  - Pop when trc_valid & trc_ready.
  - Simultaneous push and pop is allowed at any occupancy, including full; occupancy is unchanged.
  - Push when full without a pop: the record is dropped, pointers are unchanged, trc_overflow is set to 1 and holds until reset.
  - trc_pc, trc_instr and trc_addr are undefined-but-stable when trc_valid=0; the implementation drives the last slot contents.
- Counter: retire_count wraps from all-ones to 0 with no flag.

Test Plan:
- Reset and latency: STAGES=2; release reset, then if_valid=1 with if_pc=0x80000000, if_instr=0x00000013 at edge 1 -> retire_valid=1 after edge 3; pc_retire=0x80000000; instr_ctr=0x13; dmem_addr_ctr=0; retire_count=1; trc_valid=1.
- Load address: a load at 0x80000004 with mem_val=1, mem_addr=0x1000 during its MEM_STAGE cycle -> dmem_addr_ctr=0x1000 at retirement; trc_addr=0x1000.
- Stall versus kill: hold stall=1 for 3 cycles with kill[1]=1 in the 2nd cycle -> no retire_valid during or after the stall; retire_count unchanged; the stage-0 entry retires 2 cycles after stall drops.
- FIFO overflow: trc_ready=0 with 5 back-to-back retirements at TRACE_DEPTH=4 -> the 5th is dropped; trc_overflow=1; then drain with trc_ready=1 -> exactly 4 records in order, trc_valid drops, trc_overflow stays 1.
- Full simultaneous push and pop: FIFO full, retire plus trc_ready=1 on the same edge -> occupancy stays 4, no overflow; the new record appears after the existing three.
- Async reset mid-flight: assert reset low between edges with 2 stages valid and 3 records in the FIFO -> all outputs read 0 immediately; nothing retires after release.
